// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller in front
// of a fixed-latency D_RAM. Loads that hit answer in one cycle; misses and stores run the RAM.
module data_cache_ctrl #(
   parameter int MEM_LAT = 2,
   parameter int LINES   = 4
) (
   input  logic       g_clk,
   input  logic       g_clr,
   input  logic       req,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic       inv,
   output logic [7:0] rdata,
   output logic       odv,
   output logic       busy,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_ce,
   output logic       mem_we,
   input  logic [7:0] mem_rdata,
   output logic [7:0] hit_cnt,
   output logic [7:0] miss_cnt
);

   localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int TW = 8 - IW;

   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, RESP} state_t;

   typedef struct packed {
      logic          vld;
      logic [TW-1:0] tag;
      logic [7:0]    data;
   } line_t;

   state_t        state;
   line_t         lines [LINES];
   logic [3:0]    cnt;

   logic [IW-1:0] idx, l_idx;
   logic [TW-1:0] tg, l_tag;
   logic          hit, l_hit;

   // mem_addr doubles as the latched request address for the whole access
   assign idx   = addr[IW-1:0];
   assign tg    = addr[7:IW];
   assign l_idx = mem_addr[IW-1:0];
   assign l_tag = mem_addr[7:IW];
   assign hit   = lines[idx].vld && (lines[idx].tag == tg);
   assign l_hit = lines[l_idx].vld && (lines[l_idx].tag == l_tag);

   always_ff @(posedge g_clk) begin
      if (g_clr) begin
         state     <= IDLE;
         for (int i = 0; i < LINES; i++) lines[i] <= '0;
         cnt       <= '0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         odv       <= 1'b0;
         busy      <= 1'b0;
         mem_ce    <= 1'b0;
         mem_we    <= 1'b0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // invalidate wins over a concurrent request, which the requester keeps holding
               if (inv) begin
                  for (int i = 0; i < LINES; i++) lines[i].vld <= 1'b0;
               end else if (req) begin
                  busy <= 1'b1;
                  if (!we && hit) begin
                     rdata <= lines[idx].data;
                     odv   <= 1'b1;
                     state <= RESP;
                     if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
                  end else begin
                     mem_addr <= addr;
                     cnt      <= 4'(MEM_LAT);
                     mem_ce   <= 1'b1;
                     if (we) begin
                        mem_wdata <= wdata;
                        mem_we    <= 1'b1;
                        state     <= WR_THRU;
                     end else begin
                        state <= RD_MISS;
                        if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
                     end
                  end
               end
            end
            RD_MISS: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rdata          <= mem_rdata;
                  lines[l_idx]   <= '{vld: 1'b1, tag: l_tag, data: mem_rdata};
                  mem_ce         <= 1'b0;
                  odv            <= 1'b1;
                  state          <= RESP;
               end
            end
            WR_THRU: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  if (l_hit) lines[l_idx].data <= mem_wdata;
                  mem_ce <= 1'b0;
                  mem_we <= 1'b0;
                  odv    <= 1'b1;
                  state  <= RESP;
               end
            end
            RESP: begin
               odv   <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: vector table of accesses against a behavioural D_RAM,
// load results checked through a scoreboard queue popped on odv.
module tb_data_cache_ctrl;

   logic       g_clk = 1'b0;
   logic       g_clr, req, we, inv;
   logic [7:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata, hit_cnt, miss_cnt;
   logic       odv, busy, mem_ce, mem_we;

   always #5 g_clk = ~g_clk;

   data_cache_ctrl #(.MEM_LAT(2), .LINES(4)) dut (
      .g_clk(g_clk), .g_clr(g_clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .inv(inv), .rdata(rdata), .odv(odv), .busy(busy), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ce(mem_ce), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   // D_RAM: unwritten locations read as addr^0x5A
   logic         tb_init;
   logic [7:0]   ram_wr [256];
   logic [255:0] ram_wv;
   assign mem_rdata = ram_wv[mem_addr] ? ram_wr[mem_addr] : (mem_addr ^ 8'h5A);
   always @(posedge g_clk) begin
      if (tb_init) ram_wv <= '0;
      else if (mem_ce && mem_we) begin
         ram_wv[mem_addr] <= 1'b1;
         ram_wr[mem_addr] <= mem_wdata;
      end
   end

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   logic [7:0] sb [$];
   logic [7:0] sb_e;
   always @(negedge g_clk) begin
      if (odv) begin
         if (sb.size() == 0) chk("odv_unexpected", 1, 0);
         else begin
            sb_e = sb.pop_front();
            chk("rdata", int'(rdata), int'(sb_e));
         end
      end
   end

   typedef struct {
      logic       we;
      logic [7:0] addr, wdata, rdata;
      int         lat, ce, wr, hit, miss;
   } vec_t;
   vec_t tbl [9];

   task automatic do_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] exp_rd, input int e_lat, input int e_ce,
                            input int e_wr, input int e_hit, input int e_miss);
      int cyc, nce, nwe, aerr;
      bit done;
      cyc = 0; nce = 0; nwe = 0; aerr = 0; done = 0;
      @(negedge g_clk);
      req = 1'b1; we = w; addr = a; wdata = d;
      sb.push_back(exp_rd);
      while (!done && cyc < 40) begin
         @(negedge g_clk);
         cyc++;
         if (mem_ce) begin
            nce++;
            if (mem_addr != a || (w && mem_wdata != d)) aerr++;
         end
         if (mem_we) nwe++;
         if (!busy) aerr++;
         if (odv) begin
            done = 1;
            req  = 1'b0;
            chk("hit_cnt", int'(hit_cnt), e_hit);
            chk("miss_cnt", int'(miss_cnt), e_miss);
         end
      end
      if (!done) begin
         chk("odv_timeout", 0, 1);
         req = 1'b0;
      end
      chk("latency", cyc, e_lat);
      chk("mem_ce_cycles", nce, e_ce);
      chk("mem_we_cycles", nwe, e_wr);
      chk("mem_bus_or_busy_errs", aerr, 0);
   endtask

   initial begin
      g_clr = 1'b1; tb_init = 1'b1; req = 1'b0; we = 1'b0; inv = 1'b0; addr = '0; wdata = '0;

      //                 we  addr   wdata  rdata lat ce wr hit miss
      tbl[0] = '{1'b0, 8'h12, 8'h00, 8'h48, 3, 2, 0, 0, 1};
      tbl[1] = '{1'b0, 8'h12, 8'h00, 8'h48, 1, 0, 0, 1, 1};
      tbl[2] = '{1'b1, 8'h12, 8'hA5, 8'h48, 3, 2, 2, 1, 1};
      tbl[3] = '{1'b0, 8'h12, 8'h00, 8'hA5, 1, 0, 0, 2, 1};
      tbl[4] = '{1'b1, 8'h20, 8'h3C, 8'hA5, 3, 2, 2, 2, 1};
      tbl[5] = '{1'b0, 8'h20, 8'h00, 8'h3C, 3, 2, 0, 2, 2};
      tbl[6] = '{1'b0, 8'h05, 8'h00, 8'h5F, 3, 2, 0, 2, 3};
      tbl[7] = '{1'b0, 8'h45, 8'h00, 8'h1F, 3, 2, 0, 2, 4};
      tbl[8] = '{1'b0, 8'h05, 8'h00, 8'h5F, 3, 2, 0, 2, 5};

      repeat (3) @(negedge g_clk);
      g_clr = 1'b0; tb_init = 1'b0;
      @(negedge g_clk);
      chk("rst_odv", int'(odv), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_mem_ce", int'(mem_ce), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_rdata", int'(rdata), 0);
      chk("rst_hit_cnt", int'(hit_cnt), 0);
      chk("rst_miss_cnt", int'(miss_cnt), 0);

      foreach (tbl[i])
         do_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                   tbl[i].lat, tbl[i].ce, tbl[i].wr, tbl[i].hit, tbl[i].miss);

      // reset in the second RD_MISS cycle aborts the fill
      @(negedge g_clk);
      req = 1'b1; we = 1'b0; addr = 8'h33;
      @(negedge g_clk);
      chk("abort_ce_c1", int'(mem_ce), 1);
      @(negedge g_clk);
      chk("abort_ce_c2", int'(mem_ce), 1);
      g_clr = 1'b1; req = 1'b0;
      @(negedge g_clk);
      g_clr = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_mem_ce", int'(mem_ce), 0);
      chk("abort_odv", int'(odv), 0);
      chk("abort_rdata", int'(rdata), 0);
      chk("abort_miss_cnt", int'(miss_cnt), 0);
      repeat (3) begin
         @(negedge g_clk);
         chk("abort_no_odv", int'(odv), 0);
      end
      do_access(1'b0, 8'h33, 8'h00, 8'h69, 3, 2, 0, 0, 1);
      do_access(1'b0, 8'h33, 8'h00, 8'h69, 1, 0, 0, 1, 1);

      // inv with req in IDLE: request not taken, line dropped
      @(negedge g_clk);
      inv = 1'b1; req = 1'b1; we = 1'b0; addr = 8'h33;
      @(negedge g_clk);
      chk("inv_busy", int'(busy), 0);
      chk("inv_odv", int'(odv), 0);
      chk("inv_mem_ce", int'(mem_ce), 0);
      inv = 1'b0; req = 1'b0;
      do_access(1'b0, 8'h33, 8'h00, 8'h69, 3, 2, 0, 1, 2);

      // hit counter saturation
      for (int i = 0; i < 256; i++)
         do_access(1'b0, 8'h33, 8'h00, 8'h69, 1, 0, 0, (i + 2 > 255) ? 255 : i + 2, 2);
      chk("hit_cnt_sat", int'(hit_cnt), 255);

      repeat (3) @(negedge g_clk);
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL be the D_RAM access time in cycles, legal range 1..15.
REQ-002 Parameter LINES, default 4, SHALL be the number of direct-mapped 8-bit lines; tag is addr[7:2] and index is addr[1:0].
REQ-003 g_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 g_clr  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 req  in  1  SHALL be the stage-three access request, sampled only while busy=0.
REQ-006 we  in  1  SHALL select the access type: 1=store, 0=load.
REQ-007 addr  in  8  SHALL be the data address from R_OUT/PSR1.
REQ-008 wdata  in  8  SHALL be the store data.
REQ-009 inv  in  1  SHALL request invalidation of all lines.
REQ-010 rdata  out  8  SHALL be the load result, valid while odv=1.
REQ-011 odv  out  1  SHALL be the one-cycle access-complete strobe.
REQ-012 busy  out  1  SHALL be the stage-three stall to the controller.
REQ-013 mem_addr  out  8, mem_wdata  out  8, mem_ce  out  1, mem_we  out  1  SHALL drive D_RAM.
REQ-014 mem_rdata  in  8  SHALL be the D_RAM read data, valid in the last cycle of an access.
REQ-015 hit_cnt  out  8, miss_cnt  out  8  SHALL be saturating load hit/miss counters.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, RD_MISS, WR_THRU and RESP; busy=1 in every state except IDLE.
REQ-017 IDLE, req=1, we=0, line valid and tag match (hit): latch line data to rdata, go to RESP, increment hit_cnt.
REQ-018 IDLE, req=1, we=0, miss: latch addr, load counter with MEM_LAT, go to RD_MISS, increment miss_cnt.
REQ-019 IDLE, req=1, we=1: latch addr and wdata, load counter with MEM_LAT, go to WR_THRU; counters are unchanged.
REQ-020 RD_MISS: mem_ce=1, mem_we=0, mem_addr=latched addr, counter decrements each cycle.
- In the final cycle (counter=1): sample mem_rdata into rdata, fill the line (valid=1, tag, data), go to RESP.
REQ-021 WR_THRU: mem_ce=1, mem_we=1, mem_addr/mem_wdata held, counter decrements each cycle.
- On the final cycle, a hit updates the line data; a miss does not allocate.
- Then go to RESP.
REQ-022 RESP: odv=1 for exactly one cycle, then return to IDLE.
- rdata holds its value until the next load completes.
REQ-023 Latency SHALL be: load hit, odv in cycle T+1 after the req-sampling cycle T; load miss and store, odv in cycle T+MEM_LAT+1.
REQ-024 mem_ce SHALL be 0 in IDLE and RESP.
REQ-025 req while busy=1 SHALL be ignored, not queued; the requester holds req until it observes odv.
REQ-026 inv SHALL be acted on only in IDLE, clearing every valid bit at that edge.
- inv and req together in IDLE: inv takes priority; req is not accepted that cycle and busy stays 0.
REQ-027 Addresses with equal index and different tag (e.g. 0x05 and 0x45) SHALL evict each other on a load miss.
REQ-028 hit_cnt and miss_cnt SHALL stop at 255 and not wrap.

Reset
REQ-029 g_clr=1 SHALL, at the next edge and regardless of state:
- force IDLE and clear all valid bits;
- zero rdata, the counters, latched addr/data and hit_cnt/miss_cnt;
- drive odv=0, busy=0, mem_ce=0, mem_we=0.
REQ-030 A reset asserted mid-RD_MISS or mid-WR_THRU SHALL abort the access: no line fill and no odv; mem_ce=0 from the cycle after the reset edge.

Verification (MEM_LAT=2)
REQ-031 Load 0x12 after reset -> busy 3 cycles, mem_ce=1 for 2 cycles, odv at T+3 with rdata=RAM[0x12], miss_cnt=1; repeat load -> odv at T+1, hit_cnt=1, mem_ce stays 0.
REQ-032 Store 0xA5 to 0x12 (line cached) -> mem_we=1 for 2 cycles, odv at T+3; following load 0x12 hits with rdata=0xA5.
REQ-033 Store 0x3C to uncached 0x20, then load 0x20 -> the load misses (no allocate), rdata=0x3C from RAM.
REQ-034 Load 0x05, load 0x45, load 0x05 -> three misses, miss_cnt=3, hit_cnt=0.
REQ-035 Assert g_clr in the 2nd RD_MISS cycle -> next cycle busy=0 and mem_ce=0, no odv; reload of the same address misses.
REQ-036 Cached line, pulse inv in IDLE with req=1 -> req not accepted that cycle; the next load misses. Separately, 256 hits -> hit_cnt=255.
